// File: rtl/data_ptr_sequencer.sv
// data_ptr_sequencer
// Data-side sequencer for the Brainfuck data line. It accepts +, -, >, <
// and SYNC commands from the decoder and owns the data pointer on ADDRESS,
// which wraps over 0..MAX_ADDRESS. It issues one-cycle LOAD/STORE/INC/DEC
// strobes so the data counter is written back to RAM and reloaded whenever
// the pointer moves.
// Optional feature: define DATA_PTR_SEQ_DIRTY_SKIP_EN to track a dirty bit.
// When the counter is clean, RIGHT/LEFT then skip the write-back.
// All outputs are registered. Each output is decoded from the next state,
// so it lines up with the state register that is loaded on the same edge.
module data_ptr_sequencer #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int MAX_ADDRESS   = 29999
) (
  input  logic                     CLOCK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  input  logic [2:0]               CMD,
  output logic                     CMD_READY,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS,
  output logic                     LOAD,
  output logic                     STORE,
  output logic                     INC,
  output logic                     DEC,
  output logic                     CMD_ERR
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_COUNT, S_WB, S_MOVE, S_FETCH
  } state_e;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_DEC   = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_SYNC  = 3'd5;

  localparam logic [ADDRESS_WIDTH-1:0] MAX_ADDR = ADDRESS_WIDTH'(MAX_ADDRESS);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     op_dec_q, op_dec_d;    // COUNT direction
  logic                     op_left_q, op_left_d;  // MOVE direction
  logic                     op_sync_q, op_sync_d;  // WB returns to IDLE
  logic                     err_q, err_d;
  logic                     ready_q, ready_d;
  logic                     load_q, load_d;
  logic                     store_q, store_d;
  logic                     inc_q, inc_d;
  logic                     dec_q, dec_d;
`ifdef DATA_PTR_SEQ_DIRTY_SKIP_EN
  logic                     dirty_q, dirty_d;
`endif

  // State register: synchronous active-low reset drops any pending write-back.
  // NOTE: every register uses non-blocking assignment. All registers then
  // sample pre-edge values together, with no dependence on evaluation order.
  always_ff @(posedge CLOCK) begin
    if (!RST) begin
      state_q   <= S_INIT;
      addr_q    <= '0;
      op_dec_q  <= 1'b0;
      op_left_q <= 1'b0;
      op_sync_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
`ifdef DATA_PTR_SEQ_DIRTY_SKIP_EN
      dirty_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_dec_q  <= op_dec_d;
      op_left_q <= op_left_d;
      op_sync_q <= op_sync_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      load_q    <= load_d;
      store_q   <= store_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
`ifdef DATA_PTR_SEQ_DIRTY_SKIP_EN
      dirty_q   <= dirty_d;
`endif
    end
  end

  // Next-state logic: command acceptance, operand latching, pointer update.
  // NOTE: every variable gets a hold default before the case. No path can
  // then leave one unassigned, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_dec_d  = op_dec_q;
    op_left_d = op_left_q;
    op_sync_d = op_sync_q;
    err_d     = err_q;
`ifdef DATA_PTR_SEQ_DIRTY_SKIP_EN
    dirty_d   = dirty_q;
`endif
    unique case (state_q)
      // INIT holds for two cycles after reset: a LOAD cycle, then on to IDLE.
      S_INIT: if (load_q) state_d = S_IDLE;
      S_IDLE: begin
        if (CMD_VALID) begin
          unique case (CMD)
            OP_NOP: ;
            OP_INC, OP_DEC: begin
              state_d  = S_COUNT;
              op_dec_d = (CMD == OP_DEC);
`ifdef DATA_PTR_SEQ_DIRTY_SKIP_EN
              dirty_d  = 1'b1;
`endif
            end
            OP_RIGHT, OP_LEFT: begin
              op_left_d = (CMD == OP_LEFT);
              op_sync_d = 1'b0;
              state_d   = S_WB;
`ifdef DATA_PTR_SEQ_DIRTY_SKIP_EN
              if (!dirty_q) state_d = S_MOVE;
`endif
            end
            OP_SYNC: begin
              op_sync_d = 1'b1;
              state_d   = S_WB;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_COUNT: state_d = S_IDLE;
      S_WB: begin
        state_d = op_sync_q ? S_IDLE : S_MOVE;
`ifdef DATA_PTR_SEQ_DIRTY_SKIP_EN
        dirty_d = 1'b0;
`endif
      end
      S_MOVE: begin
        state_d = S_FETCH;
        if (op_left_q) addr_d = (addr_q == '0) ? MAX_ADDR : addr_q - 1'b1;
        else           addr_d = (addr_q == MAX_ADDR) ? '0 : addr_q + 1'b1;
      end
      S_FETCH: begin
        state_d = S_IDLE;
`ifdef DATA_PTR_SEQ_DIRTY_SKIP_EN
        dirty_d = 1'b0;
`endif
      end
      default: state_d = S_INIT;
    endcase
  end

  // Output decode from the next state, registered alongside the state.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    load_d  = (state_d == S_INIT) || (state_d == S_FETCH);
    store_d = (state_d == S_WB);
    inc_d   = (state_d == S_COUNT) && !op_dec_d;
    dec_d   = (state_d == S_COUNT) &&  op_dec_d;
  end

  assign CMD_READY = ready_q;
  assign ADDRESS   = addr_q;
  assign LOAD      = load_q;
  assign STORE     = store_q;
  assign INC       = inc_q;
  assign DEC       = dec_q;
  assign CMD_ERR   = err_q;

endmodule

// File: doc/data_ptr_sequencer.md
# data_ptr_sequencer

Data-side sequencer directly upstream of the data line (RAM plus data counter). Accepts decoded data-class Brainfuck operations (`+ - > <` and sync) from the instruction decoder over a valid/ready handshake. Owns the data pointer driven onto `ADDRESS`, wrapping over 0..MAX_ADDRESS. Issues one-cycle LOAD/STORE/INC/DEC strobes so the counter is written back to RAM and reloaded whenever the pointer moves.

## Interface
- ADDRESS_WIDTH, 16, data pointer width
- MAX_ADDRESS, 29999, highest valid cell; pointer wraps at this value
- CLOCK  in  1  sole clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-low
- CMD_VALID  in  1  decoder presents a command
- CMD  in  3  0=NOP, 1=INC(+), 2=DEC(-), 3=RIGHT(>), 4=LEFT(<), 5=SYNC, 6/7 illegal
- CMD_READY  out  1  sequencer can accept a command this cycle
- ADDRESS  out  ADDRESS_WIDTH  current data pointer to the data line
- LOAD  out  1  load RAM[ADDRESS] into the data counter
- STORE  out  1  write the data counter to RAM[ADDRESS]
- INC  out  1  count data counter up
- DEC  out  1  count data counter down
- CMD_ERR  out  1  sticky; set on an accepted illegal opcode

## Operation
- Handshake: a command is accepted on a rising edge with CMD_VALID=1 and CMD_READY=1. CMD_READY=1 only in IDLE.
- FSM states: INIT, IDLE, COUNT, WB, MOVE, FETCH.
- INIT: LOAD=1 for one cycle at ADDRESS=0, then IDLE. This primes the counter after reset.
- IDLE:
  - INC or DEC accepted → COUNT; dirty bit set.
  - RIGHT or LEFT accepted → WB; direction is latched.
  - SYNC accepted → WB with move suppressed: WB → IDLE, no FETCH.
  - NOP → stay in IDLE.
  - Illegal opcode → stay in IDLE and set CMD_ERR.
- COUNT: INC or DEC =1 for exactly one cycle, then IDLE.
- WB: STORE=1 for one cycle; dirty bit cleared. Then MOVE, or IDLE if SYNC.
- MOVE: ADDRESS updated, all strobes low for one cycle, then FETCH.
  - RIGHT: ADDRESS = (ADDRESS==MAX_ADDRESS) ? 0 : ADDRESS+1.
  - LEFT: ADDRESS = (ADDRESS==0) ? MAX_ADDRESS : ADDRESS−1.
- FETCH: LOAD=1 for one cycle at the new ADDRESS, then IDLE; dirty bit cleared.
- Strobes are mutually exclusive: at most one of LOAD/STORE/INC/DEC is high in any cycle.
- ADDRESS is stable in every cycle where any strobe is high. It changes only on the edge leaving MOVE.
- CMD is sampled only at acceptance; later changes on CMD are ignored.

## Timing
- Reset values (RST=0 at an edge): ADDRESS=0, LOAD=STORE=INC=DEC=0, CMD_READY=0, CMD_ERR=0, dirty=0, state=INIT.
- Reset is honoured in any state, including mid-move. Any pending write-back is discarded; no STORE is issued.
- Cycle numbering: acceptance edge = cycle 0.
  - INC/DEC: strobe high in cycle 1; CMD_READY high in cycle 2. Throughput is one count op per 2 cycles.
  - Move, with write-back: STORE in cycle 1, MOVE in cycle 2, LOAD in cycle 3; CMD_READY high in cycle 4.
  - Move, write-back skipped (see Configuration): MOVE in cycle 1, LOAD in cycle 2; CMD_READY high in cycle 3.
  - SYNC: STORE in cycle 1; CMD_READY high in cycle 2.
- After reset release: LOAD high in the first cycle; CMD_READY high in the second.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: DATA_PTR_SEQ_DIRTY_SKIP_EN.
- Defined: if the dirty bit is 0 when RIGHT/LEFT is accepted, the sequencer goes IDLE → MOVE directly, skipping WB (no STORE). SYNC always stores regardless of dirty.
- Undefined: every RIGHT/LEFT passes through WB; the dirty bit is not implemented.

## Test plan
- Reset, then release → LOAD pulses once at ADDRESS=0; CMD_READY rises in the next cycle; all other strobes 0.
- Three INC commands back-to-back, then one DEC → INC high in exactly 3 cycles and DEC in 1, each 2 cycles apart. ADDRESS stays 0.
- INC, then RIGHT → STORE at ADDRESS=0, ADDRESS becomes 1, LOAD at 1. CMD_READY rises 4 cycles after RIGHT is accepted.
- LEFT from 0 → ADDRESS=29999 with LOAD there. Then RIGHT → ADDRESS=0.
  - With DATA_PTR_SEQ_DIRTY_SKIP_EN defined, neither move issues STORE.
  - With it undefined, each move issues one STORE.
- CMD=7 accepted → CMD_ERR=1 and stays 1. No strobe fires. Next INC is accepted normally.
- RST driven low during the MOVE cycle of a RIGHT from ADDRESS=5 → ADDRESS=0 at that edge, with no LOAD at 6. The INIT LOAD at 0 follows release.
